csa_accumulator_tree: RTL and testbench

- Pipelined, parametrised carry-save reduction tree with a carry-save accumulator and a final carry-propagate resolve.
- Reduces NUM_INPUTS operands per beat through registered 4:2 compressor levels.
- Accumulates successive beats in redundant (sum/carry) form until a beat marked last, then emits one resolved result.
- Sits between the multiplier partial-product stage and the output writeback in the compute datapath.

---
 rtl/csa_accumulator_tree_pkg.sv | 30 +++
 rtl/csa_accumulator_tree_if.sv | 33 +++
 rtl/csa_accumulator_tree_compressor_4_2_row.sv | 37 +++
 rtl/csa_accumulator_tree.sv | 174 +++++++++++++++++
 tb/tb_csa_accumulator_tree.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/csa_accumulator_tree_pkg.sv
// csa_pkg: shared types and helpers for the carry-save accumulator tree.
//   num_levels()   number of registered 4:2 levels needed to reduce N operands to a pair
//   acc_state_e    accumulate-stage state (first beat of a group / accumulating)
//   csa_pair_t     redundant sum/carry pair at the default result width
//   csa_sideband_t per-stage valid/last tag travelling with the data
package csa_pkg;

  localparam int CSA_OUTPUT_WIDTH = 20;

  typedef enum logic [0:0] {
    ACC_FIRST = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic [CSA_OUTPUT_WIDTH-1:0] sum;
    logic [CSA_OUTPUT_WIDTH-1:0] carry;
  } csa_pair_t;

  typedef struct packed {
    logic valid;
    logic last;
  } csa_sideband_t;

  // Each 4:2 level halves the operand count; stop once two vectors remain.
  function automatic int num_levels(input int num_inputs);
    return $clog2(num_inputs) - 1;
  endfunction

endpackage

// File: rtl/csa_accumulator_tree_if.sv
// csa_accumulator_tree_if: beat input and result output handshake bundle.
//   in_valid/in_ready/in_data/in_signed/in_last : operand beats toward the tree
//   out_valid/out_ready/out_result/out_beats    : resolved group results
//   master: producer/consumer side (bench), slave: the accumulator tree
interface csa_accumulator_tree_if #(
  parameter int NUM_INPUTS   = 8,
  parameter int INPUT_WIDTH  = 14,
  parameter int OUTPUT_WIDTH = 20,
  parameter int COUNT_WIDTH  = 8
);
  import csa_pkg::*;

  logic                                   in_valid;
  logic                                   in_ready;
  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] in_data;
  logic                                   in_signed;
  logic                                   in_last;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [OUTPUT_WIDTH-1:0]                out_result;
  logic [COUNT_WIDTH-1:0]                 out_beats;

  modport master (
    output in_valid, in_data, in_signed, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_last, out_ready,
    output in_ready, out_valid, out_result, out_beats
  );

endinterface

// File: rtl/csa_accumulator_tree_compressor_4_2_row.sv
// compressor_4_2_row: a row of 4:2 compressor bit cells built from two full adders.
//   a, b, c, d : four WIDTH-bit addends
//   sum        : bitwise sum vector
//   carry      : carry vector, already shifted left by one (bit 0 is zero)
// sum + carry == a + b + c + d modulo 2^WIDTH. The first full adder's carry
// (cout) ripples exactly one position into the next cell's second full adder.
module compressor_4_2_row
  import csa_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] cin;
  logic [WIDTH-2:0] cout;
  logic [WIDTH-2:0] cy;

  // Two full-adder layers; the top cell's carries fall off (modulo arithmetic).
  always_comb begin
    s1    = a ^ b ^ c;
    cout  = (a[WIDTH-2:0] & b[WIDTH-2:0]) | (a[WIDTH-2:0] & c[WIDTH-2:0]) |
            (b[WIDTH-2:0] & c[WIDTH-2:0]);
    cin   = {cout, 1'b0};
    sum   = s1 ^ d ^ cin;
    cy    = (s1[WIDTH-2:0] & d[WIDTH-2:0]) | (s1[WIDTH-2:0] & cin[WIDTH-2:0]) |
            (d[WIDTH-2:0] & cin[WIDTH-2:0]);
    carry = {cy, 1'b0};
  end

endmodule

// File: rtl/csa_accumulator_tree.sv
// csa_accumulator_tree: pipelined carry-save reduction of NUM_INPUTS operands per
// beat, carry-save accumulation across a group of beats, and a final resolve add.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of csa_accumulator_tree_if (beats in, results out)
// Pipeline: input register -> L registered 4:2 levels -> accumulator -> resolve.
// The whole pipeline freezes while a result is held un-accepted downstream.
module csa_accumulator_tree
  import csa_pkg::*;
#(
  parameter int NUM_INPUTS   = 8,
  parameter int INPUT_WIDTH  = 14,
  parameter int OUTPUT_WIDTH = 20,
  parameter int COUNT_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  csa_accumulator_tree_if.slave bus
);

  localparam int L   = num_levels(NUM_INPUTS);
  localparam int EXT = OUTPUT_WIDTH - INPUT_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic stall;
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  logic [NUM_INPUTS-1:0][OUTPUT_WIDTH-1:0] ext_s;
  logic [NUM_INPUTS-1:0][OUTPUT_WIDTH-1:0] in_q;
  csa_sideband_t                           in_sb_q;

  // Zero- or sign-extend every operand of the incoming beat.
  always_comb begin
    ext_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (bus.in_signed) begin
        ext_s[i] = {{EXT{bus.in_data[i][INPUT_WIDTH-1]}}, bus.in_data[i]};
      end else begin
        ext_s[i] = {{EXT{1'b0}}, bus.in_data[i]};
      end
    end
  end

  // Input register; payload only loads on a valid beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_sb_q <= '0;
    end else if (!stall) begin
      in_sb_q.valid <= bus.in_valid;
      in_sb_q.last  <= bus.in_valid && bus.in_last;
      if (bus.in_valid) begin
        in_q <= ext_s;
      end
    end
  end

  generate
    for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int NI = NUM_INPUTS >> k;
      localparam int NO = NI / 2;

      logic [NI-1:0][OUTPUT_WIDTH-1:0] opnd;
      logic [NO-1:0][OUTPUT_WIDTH-1:0] row_s;
      logic [NO-1:0][OUTPUT_WIDTH-1:0] q;
      csa_sideband_t                   sb_in;
      csa_sideband_t                   sb_q;

      if (k == 0) begin : g_src
        assign opnd  = in_q;
        assign sb_in = in_sb_q;
      end else begin : g_src
        assign opnd  = g_lvl[k-1].q;
        assign sb_in = g_lvl[k-1].sb_q;
      end

      for (genvar j = 0; j < NI / 4; j++) begin : g_row
        compressor_4_2_row #(.WIDTH(OUTPUT_WIDTH)) u_row (
          .a     (opnd[4*j]),
          .b     (opnd[4*j+1]),
          .c     (opnd[4*j+2]),
          .d     (opnd[4*j+3]),
          .sum   (row_s[2*j]),
          .carry (row_s[2*j+1])
        );
      end

      // Level register carrying the reduced vectors plus valid/last.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sb_q <= '0;
        end else if (!stall) begin
          sb_q <= sb_in;
          if (sb_in.valid) begin
            q <= row_s;
          end
        end
      end
    end
  endgenerate

  logic [1:0][OUTPUT_WIDTH-1:0] tree_q;
  csa_sideband_t                tree_sb;
  assign tree_q  = g_lvl[L-1].q;
  assign tree_sb = g_lvl[L-1].sb_q;

  acc_state_e              state;
  logic [OUTPUT_WIDTH-1:0] acc_sum;
  logic [OUTPUT_WIDTH-1:0] acc_carry;
  logic [OUTPUT_WIDTH-1:0] nxt_sum;
  logic [OUTPUT_WIDTH-1:0] nxt_carry;
  logic [COUNT_WIDTH-1:0]  count;
  logic                    acc_done;

  compressor_4_2_row #(.WIDTH(OUTPUT_WIDTH)) u_acc_row (
    .a     (tree_q[0]),
    .b     (tree_q[1]),
    .c     (acc_sum),
    .d     (acc_carry),
    .sum   (nxt_sum),
    .carry (nxt_carry)
  );

  // Accumulate FSM: the first beat of a group overwrites the accumulator so
  // no residue from the previous group survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACC_FIRST;
      acc_sum   <= '0;
      acc_carry <= '0;
      count     <= '0;
      acc_done  <= 1'b0;
    end else if (!stall) begin
      acc_done <= tree_sb.valid && tree_sb.last;
      if (tree_sb.valid) begin
        case (state)
          ACC_FIRST: begin
            acc_sum   <= tree_q[0];
            acc_carry <= tree_q[1];
            count     <= COUNT_ONE;
            state     <= tree_sb.last ? ACC_FIRST : ACC_ACCUM;
          end
          ACC_ACCUM: begin
            acc_sum   <= nxt_sum;
            acc_carry <= nxt_carry;
            if (count != {COUNT_WIDTH{1'b1}}) begin
              count <= count + COUNT_ONE;
            end
            state <= tree_sb.last ? ACC_FIRST : ACC_ACCUM;
          end
          default: begin
            state <= ACC_FIRST;
          end
        endcase
      end
    end
  end

  // Resolve stage: carry-propagate add of the completed group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_beats  <= '0;
    end else if (!stall) begin
      bus.out_valid <= acc_done;
      if (acc_done) begin
        bus.out_result <= acc_sum + acc_carry;
        bus.out_beats  <= count;
      end
    end
  end

endmodule

// File: tb/tb_csa_accumulator_tree.sv
// Self-checking bench for csa_accumulator_tree: directed literal cases plus
// randomized groups under backpressure, against a plain-arithmetic group model.
module tb_csa_accumulator_tree;

  localparam int N  = 8;
  localparam int IW = 14;
  localparam int OW = 20;
  localparam int CW = 8;

  typedef logic [N-1:0][IW-1:0] beat_t;
  typedef struct packed {
    logic [OW-1:0] res;
    logic [CW-1:0] beats;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_accumulator_tree_if #(.NUM_INPUTS(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
                            .COUNT_WIDTH(CW)) bus ();

  csa_accumulator_tree #(.NUM_INPUTS(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
                         .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Sum of one beat's operands as signed/unsigned integers, reduced mod 2^OW.
  function automatic logic [OW-1:0] beat_sum(input beat_t d, input logic sgn);
    int total = 0;
    for (int i = 0; i < N; i++) begin
      int v = int'(d[i]);
      if (sgn && d[i][IW-1]) v = v - (1 << IW);
      total = total + v;
    end
    return OW'(total);
  endfunction

  function automatic beat_t fill(input logic [IW-1:0] v);
    beat_t d;
    for (int i = 0; i < N; i++) d[i] = v;
    return d;
  endfunction

  // Reference model and per-cycle compare, sampled on the falling edge.
  initial begin : monitor
    logic [OW-1:0] m_acc = '0;
    logic [CW-1:0] m_beats = '0;
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_res = '0;
    logic [CW-1:0] prev_beats = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_acc = '0;
        m_beats = '0;
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          m_acc = m_acc + beat_sum(bus.in_data, bus.in_signed);
          if (m_beats != 8'hFF) m_beats = m_beats + 8'd1;
          if (bus.in_last) begin
            exp_q.push_back('{res: m_acc, beats: m_beats});
            m_acc = '0;
            m_beats = '0;
          end
        end
        check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
        if (prev_stall) begin
          check("hold_result", 32'(bus.out_result), 32'(prev_res));
          check("hold_beats", 32'(bus.out_beats), 32'(prev_beats));
        end
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
          end else begin
            check("model_result", 32'(bus.out_result), 32'(exp_q[0].res));
            check("model_beats", 32'(bus.out_beats), 32'(exp_q[0].beats));
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              pulses++;
            end
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_res   = bus.out_result;
        prev_beats = bus.out_beats;
      end
    end
  end

  task automatic send_beat(input beat_t d, input logic sgn, input logic last);
    int t = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_signed = sgn;
    bus.in_last   = last;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called right after the last beat's accepting edge; result due 4 edges later.
  task automatic expect_result(input string name, input logic [OW-1:0] r, input logic [CW-1:0] b);
    int lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd4);
    check({name, "_result"}, 32'(bus.out_result), 32'(r));
    check({name, "_beats"}, 32'(bus.out_beats), 32'(b));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int    p0;
    beat_t rd;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_result", 32'(bus.out_result), 32'd0);
    check("reset_out_beats", 32'(bus.out_beats), 32'd0);
    rst_n = 1'b1;

    send_beat(fill(14'h3FFF), 1'b0, 1'b1);
    expect_result("unsigned_single", 20'h1FFF8, 8'd1);
    send_beat(fill(14'h3FFF), 1'b1, 1'b1);
    expect_result("signed_single", 20'hFFFF8, 8'd1);

    p0 = pulses;
    for (int i = 0; i < 3; i++) send_beat(fill(14'd1), 1'b0, i == 2);
    expect_result("accum", 20'd24, 8'd3);
    repeat (8) @(posedge clk);
    #1;
    check("accum_pulses", 32'(pulses - p0), 32'd1);

    for (int i = 0; i < 64; i++) send_beat(fill(14'h3FFF), 1'b0, i == 63);
    expect_result("wrap", 20'hFFE00, 8'd64);

    // Two beats of a group in flight, then reset; only the new group must emerge.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < N; j++) rd[j] = IW'($urandom);
      send_beat(rd, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pulses;
    send_beat(fill(14'd1), 1'b0, 1'b1);
    expect_result("reset_mid", 20'd8, 8'd1);
    repeat (8) @(posedge clk);
    #1;
    check("reset_mid_pulses", 32'(pulses - p0), 32'd1);

    // Random groups of two with a 5-cycle stall after every result.
    p0 = pulses;
    bus.out_ready = 1'b0;
    fork
      begin
        beat_t d;
        for (int i = 0; i < 20; i++) begin
          for (int j = 0; j < N; j++) d[j] = IW'($urandom);
          send_beat(d, 1'($urandom_range(0, 1)), (i % 2) == 1);
        end
      end
      begin
        for (int r = 0; r < 10; r++) begin
          int t = 0;
          @(negedge clk);
          while (!bus.out_valid && t < 200) begin
            @(negedge clk);
            t++;
          end
          if (t >= 200) check("result_timeout", 32'(bus.out_valid), 32'd1);
          repeat (5) @(posedge clk);
          #1;
          bus.out_ready = 1'b1;
          @(posedge clk);
          #1;
          bus.out_ready = 1'b0;
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("random_results", 32'(pulses - p0), 32'd10);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
